// File: rtl/m6502_bus_bridge.sv
// Bridges single-cycle 6502-style read/write pulses onto a level-strobed memory bus with ack handshake.
// Optional timeout abort is compiled in with `define M6502_BUS_TIMEOUT_EN.
module m6502_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        rd_req,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_timeout;
    logic [15:0] r_memAddr;
    logic [7:0]  r_memWdata;
    logic [7:0]  r_rdData;

`ifdef M6502_BUS_TIMEOUT_EN
    logic [7:0] r_count;
    logic       r_busErr;

    // Ack wins over a timeout landing on the same edge.
    assign w_timeout = (r_state != IDLE) && !mem_ack && (r_count == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 8'd0;
            r_busErr <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_count <= 8'd0;
            else if (!mem_ack)
                r_count <= r_count + 8'd1;
            if (w_timeout)
                r_busErr <= 1'b1;
        end
    end

    assign bus_err = r_busErr;
`else
    logic [7:0] w_unusedLimit;

    assign w_unusedLimit = 8'(TIMEOUT_CYCLES);
    assign w_timeout     = 1'b0;
    assign bus_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (wr_en)
                    w_nextState = WRITE;
                else if (rd_req)
                    w_nextState = READ;
            end
            READ, WRITE: begin
                if (mem_ack || w_timeout)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        ready  = (r_state == IDLE);
        mem_rd = (r_state == READ);
        mem_wr = (r_state == WRITE);
    end

    // Address/data are captured only on acceptance so they stay put for the whole strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_memAddr  <= 16'd0;
            r_memWdata <= 8'd0;
            r_rdData   <= 8'd0;
        end else begin
            if (r_state == IDLE) begin
                if (wr_en) begin
                    r_memAddr  <= addr;
                    r_memWdata <= wr_data;
                end else if (rd_req) begin
                    r_memAddr <= addr;
                end
            end else if (r_state == READ) begin
                if (mem_ack)
                    r_rdData <= mem_rdata;
                else if (w_timeout)
                    r_rdData <= 8'hFF;
            end
        end
    end

    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign rd_data   = r_rdData;

endmodule

// File: tb/tb_m6502_bus_bridge.sv
// Scoreboard bench for m6502_bus_bridge: stimulus queues expected completions, a monitor checks them.
// Timeout expectations follow M6502_BUS_TIMEOUT_EN.
module tb_m6502_bus_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        rd_req;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        ready;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    typedef struct {
        logic [7:0] rdData;
        logic       busErr;
        int         rdCycles;
        int         wrCycles;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   errorCount = 0;

    m6502_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .rd_req    (rd_req),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                                 input logic push, input logic [7:0] expRd, input logic expErr,
                                 input int expRdCyc, input int expWrCyc, input string name);
        exp_t e;
        rd_req  = rd;
        wr_en   = wr;
        addr    = a;
        wr_data = d;
        if (push) begin
            e.rdData   = expRd;
            e.busErr   = expErr;
            e.rdCycles = expRdCyc;
            e.wrCycles = expWrCyc;
            e.name     = name;
            expQ.push_back(e);
        end
        tick();
        rd_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    // Monitor: counts strobe cycles and scores each ready rising edge against the queue.
    initial begin : monitor
        logic prevReady;
        int   rdCyc;
        int   wrCyc;
        exp_t e;
        prevReady = 1'b1;
        rdCyc     = 0;
        wrCyc     = 0;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                rdCyc     = 0;
                wrCyc     = 0;
                prevReady = 1'b1;
            end else begin
                if (mem_rd) rdCyc++;
                if (mem_wr) wrCyc++;
                if (mem_rd && mem_wr) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL strobeOverlap: got rd=%b wr=%b expected one-hot", mem_rd, mem_wr);
                end
                if (ready && !prevReady) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL unexpectedCompletion: got completion expected none");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.name, ".rdData"}, 16'(rd_data), 16'(e.rdData));
                        checkOutput({e.name, ".busErr"}, 16'(bus_err), 16'(e.busErr));
                        checkOutput({e.name, ".rdCycles"}, 16'(rdCyc), 16'(e.rdCycles));
                        checkOutput({e.name, ".wrCycles"}, 16'(wrCyc), 16'(e.wrCycles));
                    end
                    rdCyc = 0;
                    wrCyc = 0;
                end
                prevReady = ready;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset_n   = 1'b0;
        rd_req    = 1'b0;
        wr_en     = 1'b0;
        addr      = 16'd0;
        wr_data   = 8'd0;
        mem_rdata = 8'd0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.ready", 16'(ready), 16'd1);
        checkOutput("rst.memRd", 16'(mem_rd), 16'd0);
        checkOutput("rst.memWr", 16'(mem_wr), 16'd0);
        checkOutput("rst.memAddr", mem_addr, 16'h0000);
        checkOutput("rst.memWdata", 16'(mem_wdata), 16'h0000);
        checkOutput("rst.rdData", 16'(rd_data), 16'h0000);
        checkOutput("rst.busErr", 16'(bus_err), 16'd0);
        reset_n = 1'b1;

        // Read accepted at the first edge after reset release, acked immediately.
        applyStimulus(1'b1, 1'b0, 16'hFFFC, 8'h00, 1'b1, 8'h34, 1'b0, 1, 0, "read");
        checkOutput("read.memRd", 16'(mem_rd), 16'd1);
        checkOutput("read.ready", 16'(ready), 16'd0);
        checkOutput("read.memAddr", mem_addr, 16'hFFFC);
        mem_ack   = 1'b1;
        mem_rdata = 8'h34;
        tick();
        mem_ack = 1'b0;
        checkOutput("read.readyBack", 16'(ready), 16'd1);
        checkOutput("read.memRdDrop", 16'(mem_rd), 16'd0);

        // Write with three wait states.
        applyStimulus(1'b0, 1'b1, 16'h0200, 8'hA5, 1'b1, 8'h34, 1'b0, 0, 4, "write");
        for (int i = 0; i < 4; i++) begin
            checkOutput("write.memWr", 16'(mem_wr), 16'd1);
            checkOutput("write.memAddr", mem_addr, 16'h0200);
            checkOutput("write.memWdata", 16'(mem_wdata), 16'h00A5);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        checkOutput("write.readyBack", 16'(ready), 16'd1);
        checkOutput("write.memWrDrop", 16'(mem_wr), 16'd0);

        // Simultaneous read and write: write wins.
        applyStimulus(1'b1, 1'b1, 16'h0010, 8'h5A, 1'b1, 8'h34, 1'b0, 0, 1, "rdwr");
        checkOutput("rdwr.memWr", 16'(mem_wr), 16'd1);
        checkOutput("rdwr.memRd", 16'(mem_rd), 16'd0);
        checkOutput("rdwr.memAddr", mem_addr, 16'h0010);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // Second read while one is pending is dropped.
        applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 8'h77, 1'b0, 2, 0, "dualrd");
        applyStimulus(1'b1, 1'b0, 16'h5678, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, "ignored");
        checkOutput("dualrd.memRd", 16'(mem_rd), 16'd1);
        checkOutput("dualrd.memAddr", mem_addr, 16'h1234);
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        checkOutput("dualrd.ready", 16'(ready), 16'd1);

        // Stray ack while idle changes nothing.
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        checkOutput("idleAck.ready", 16'(ready), 16'd1);
        checkOutput("idleAck.memRd", 16'(mem_rd), 16'd0);
        checkOutput("idleAck.rdData", 16'(rd_data), 16'h0077);
        checkOutput("idleAck.memAddr", mem_addr, 16'h1234);
        tick();
        checkOutput("idleAck.noExtraRd", 16'(mem_rd), 16'd0);

`ifdef M6502_BUS_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 16'h3000, 8'h00, 1'b1, 8'hFF, 1'b1, 4, 0, "timeout");
        repeat (3) tick();
        checkOutput("timeout.stillBusy", 16'(mem_rd), 16'd1);
        checkOutput("timeout.notReady", 16'(ready), 16'd0);
        tick();
        checkOutput("timeout.ready", 16'(ready), 16'd1);
        checkOutput("timeout.memRd", 16'(mem_rd), 16'd0);
        checkOutput("timeout.rdData", 16'(rd_data), 16'h00FF);
        checkOutput("timeout.busErr", 16'(bus_err), 16'd1);
        applyStimulus(1'b1, 1'b0, 16'h3001, 8'h00, 1'b1, 8'h22, 1'b1, 1, 0, "sticky");
        mem_ack   = 1'b1;
        mem_rdata = 8'h22;
        tick();
        mem_ack = 1'b0;
        checkOutput("sticky.busErr", 16'(bus_err), 16'd1);
`else
        applyStimulus(1'b1, 1'b0, 16'h3000, 8'h00, 1'b1, 8'h11, 1'b0, 301, 0, "noTimeout");
        repeat (300) tick();
        checkOutput("noTimeout.memRd", 16'(mem_rd), 16'd1);
        checkOutput("noTimeout.ready", 16'(ready), 16'd0);
        checkOutput("noTimeout.busErr", 16'(bus_err), 16'd0);
        checkOutput("noTimeout.memAddr", mem_addr, 16'h3000);
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
`endif

        // Reset in the middle of a read, then a late ack for it.
        applyStimulus(1'b1, 1'b0, 16'hABCD, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, "aborted");
        checkOutput("abort.memRdBefore", 16'(mem_rd), 16'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort.ready", 16'(ready), 16'd1);
        checkOutput("abort.memRd", 16'(mem_rd), 16'd0);
        checkOutput("abort.memAddr", mem_addr, 16'h0000);
        checkOutput("abort.memWdata", 16'(mem_wdata), 16'h0000);
        checkOutput("abort.rdData", 16'(rd_data), 16'h0000);
        checkOutput("abort.busErr", 16'(bus_err), 16'd0);
        #1;
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        checkOutput("abort.lateAckReady", 16'(ready), 16'd1);
        checkOutput("abort.lateAckMemRd", 16'(mem_rd), 16'd0);
        checkOutput("abort.lateAckRdData", 16'(rd_data), 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'h0042, 8'h00, 1'b1, 8'h5C, 1'b0, 1, 0, "postRst");
        checkOutput("postRst.memAddr", mem_addr, 16'h0042);
        mem_ack   = 1'b1;
        mem_rdata = 8'h5C;
        tick();
        mem_ack = 1'b0;
        repeat (2) tick();
        checkOutput("queueEmpty", 16'(expQ.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
